// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [3:0]      OPC_HALT      = 4'hF;
  localparam logic [XLEN-1:0] PC_STEP       = 16'h2;
  localparam logic [XLEN-1:0] RESET_PC      = 16'h0000;
  // Instructions are halfword aligned, so redirect targets drop bit 0.
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 16'hFFFE;

endpackage

// File: rtl/rca_16bit.sv
// 16-bit ripple-carry adder used for the PC increment.
module rca_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] carry;

  always_comb begin
    sum   = '0;
    carry = '0;
    carry[0] = cin;
    for (int i = 0; i < 16; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[16];
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect and HALT detection.
// Define FETCH_COUNT_EN to add the saturating fetch_count handshake counter.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0] fetch_count
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus2;
  logic [XLEN-1:0] instr_d, instr_pc_d;
  logic            req_d, valid_d, halted_d;
  logic            pc_cout_unused;

  rca_16bit u_pc_inc (
    .a    (pc_q),
    .b    (PC_STEP),
    .cin  (1'b0),
    .sum  (pc_plus2),
    .cout (pc_cout_unused)
  );

  assign imem_addr = pc_q;

  // Next-state, next-PC and next-output decode; redirect outranks ack/ready.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr;
    instr_pc_d = instr_pc;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc & PC_ALIGN_MASK;
        end
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect) begin
          pc_d    = redirect_pc & PC_ALIGN_MASK;
          state_d = ST_FETCH;
        end else if (imem_ack) begin
          instr_d    = imem_data;
          instr_pc_d = pc_q;
          pc_d       = pc_plus2;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc & PC_ALIGN_MASK;
          state_d = ST_FETCH;
        end else if (instr_ready) begin
          state_d = (instr[15:12] == OPC_HALT) ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_d    = (state_d == ST_FETCH);
    valid_d  = (state_d == ST_HOLD);
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_req    <= req_d;
      instr_valid <= valid_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      halted      <= halted_d;
    end
  end

`ifdef FETCH_COUNT_EN
  logic handshake;

  // A redirect in HOLD pre-empts the handshake, so discarded words never count.
  assign handshake = (state_q == ST_HOLD) && instr_ready && !redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
    end else if (handshake && (fetch_count != 16'hFFFF)) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port imem_req, output, 1 bit: instruction memory read request.
REQ-004 The block SHALL have the port imem_addr, output, 16 bits: read byte address, always equal to the current PC.
REQ-005 The block SHALL have the port imem_ack, input, 1 bit: read data valid this cycle; meaningful only while imem_req=1.
REQ-006 The block SHALL have the port imem_data, input, 16 bits: instruction word, sampled when imem_ack=1.
REQ-007 The block SHALL have the port instr_valid, output, 1 bit: instr and instr_pc hold a fetched instruction for decode.
REQ-008 The block SHALL have the port instr, output, 16 bits: fetched instruction word.
REQ-009 The block SHALL have the port instr_pc, output, 16 bits: address the instruction was fetched from.
REQ-010 The block SHALL have the port instr_ready, input, 1 bit: decode accepts instr this cycle.
REQ-011 The block SHALL have the port redirect, input, 1 bit: branch-control request to load a new PC.
REQ-012 The block SHALL have the port redirect_pc, input, 16 bits: target PC, i.e. the computed next-PC value.
REQ-013 The block SHALL have the port halted, output, 1 bit: a HALT instruction has been consumed by decode.

Function
REQ-014 The block SHALL implement the states IDLE, FETCH, HOLD and HALT, all registered.
REQ-015 In IDLE, the block SHALL keep imem_req=0 and SHALL move to FETCH on the next edge unconditionally.
REQ-016 In FETCH, the block SHALL assert imem_req=1 with imem_addr=pc.
REQ-017 In FETCH, on imem_ack=1 the block SHALL capture instr=imem_data and instr_pc=pc, update pc to pc+2, and move to HOLD.
REQ-018 In HOLD, the block SHALL hold imem_req=0 and instr_valid=1, with instr and instr_pc stable until the handshake.
REQ-019 In HOLD, when instr_ready=1 the block SHALL complete the handshake and move to HALT if instr[15:12]=4'hF, otherwise to FETCH.
REQ-020 In HALT, the block SHALL set halted=1, imem_req=0 and instr_valid=0, and SHALL leave HALT only on reset.
REQ-021 In IDLE, FETCH or HOLD, redirect=1 SHALL take priority over imem_ack and instr_ready.
REQ-022 On redirect, the block SHALL set pc=redirect_pc with bit 0 forced to 0.
REQ-023 On redirect, the block SHALL discard any same-cycle ack data, drop instr_valid on the next cycle, and move to FETCH.
REQ-024 In HALT, redirect SHALL be ignored.
REQ-025 The block SHALL keep at most one memory read outstanding and SHALL keep imem_addr constant while imem_req=1, except on redirect.
REQ-026 PC arithmetic SHALL be 16-bit modulo, so 0xFFFE+2 wraps to 0x0000 with no error indication.
REQ-027 The latency from imem_ack to instr_valid=1 SHALL be one cycle.
REQ-028 The minimum cycle from one handshake to the next imem_req SHALL be one cycle.

Reset
REQ-029 While rst=0, the block SHALL force state=IDLE, pc=0x0000, imem_req=0, instr_valid=0, instr=0x0000, instr_pc=0x0000 and halted=0, asynchronously.
REQ-030 Reset asserted mid-fetch SHALL abandon the outstanding read, and any imem_ack that follows SHALL be ignored until FETCH is re-entered.
REQ-031 Reset deassertion SHALL take effect at the next clk edge, and the first request SHALL be issued at address 0x0000.

Configuration
REQ-032 When FETCH_COUNT_EN is defined, the block SHALL add output fetch_count, 16 bits, reset to 0x0000.
REQ-033 With FETCH_COUNT_EN, fetch_count SHALL increment on each instr_valid & instr_ready handshake, saturate at 0xFFFF, and not count redirect-discarded words.
REQ-034 When FETCH_COUNT_EN is not defined, the fetch_count port and its counter logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-035 Shared package fetch_pkg SHALL hold: the state enum, OPC_HALT=4'hF, PC_STEP=16'h2 and RESET_PC=16'h0000.
REQ-036 The pc+2 increment SHALL be performed by one instance of the existing rca_16bit adder sub-module, with cin=0.

Verification
REQ-037 Bench scenario: release reset, ack every request after 2 cycles, instr_ready=1 -> addresses 0x0000, 0x0002, 0x0004, and instr_pc matches each.
REQ-038 Bench scenario: hold instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc stable, imem_req=0 throughout.
REQ-039 Bench scenario: redirect=1, redirect_pc=0x1235 in the same cycle as imem_ack -> data discarded, next imem_addr=0x1234.
REQ-040 Bench scenario: fetch 0xF000 at 0x0010 and accept it -> halted=1 next cycle, no further imem_req, redirect ignored.
REQ-041 Bench scenario: redirect to 0xFFFE, ack -> the following request is at address 0x0000.
REQ-042 Bench scenario: drop rst while in FETCH, then ack -> all outputs return to reset values and the late ack is ignored; with FETCH_COUNT_EN, fetch_count returns to 0.
